// File: rtl/mesi_snoop_bus_ctrl.sv
// Snooping-bus controller: arbitrates BusRd/BusRdX/BusUpgr from NUM_CACHES MESI caches and sequences snoop/flush/fill.
// Define MESI_BUS_FIXED_PRIO_EN for fixed lowest-index-wins arbitration instead of round-robin.
module mesi_snoop_bus_ctrl #(
  parameter int unsigned NUM_CACHES  = 4,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic [NUM_CACHES-1:0] BusRd_out,
  input  logic [NUM_CACHES-1:0] BusRdX_out,
  input  logic [NUM_CACHES-1:0] BusUpgr_out,
  input  logic [NUM_CACHES-1:0] Flush,
  input  logic [NUM_CACHES-1:0] Shared,
  output logic [NUM_CACHES-1:0] BusRd_in,
  output logic [NUM_CACHES-1:0] BusRdX_in,
  output logic [NUM_CACHES-1:0] BusUpgr_in,
  output logic [NUM_CACHES-1:0] C_in,
  output logic [NUM_CACHES-1:0] grant,
  output logic [NUM_CACHES-1:0] xfer_done,
  output logic                  mem_rd,
  output logic                  busy,
  output logic                  protocol_err
);
  localparam int unsigned IDXW = $clog2(NUM_CACHES);

  typedef enum logic [2:0] {S_IDLE, S_BCAST, S_SNOOP, S_MEM, S_DONE} state_t;
  typedef enum logic [1:0] {CMD_RD, CMD_RDX, CMD_UPGR} cmd_t;

  state_t                state;
  cmd_t                  cmd;
  logic [3:0]            mem_cnt;
  logic [NUM_CACHES-1:0] req;
  logic [NUM_CACHES-1:0] pick_oh;
  logic [NUM_CACHES-1:0] snoop_shared;
  logic [NUM_CACHES-1:0] snoop_flush;
  logic [IDXW-1:0]       pick_idx;
  logic [IDXW-1:0]       scan;
  logic                  pick_valid;
`ifndef MESI_BUS_FIXED_PRIO_EN
  logic [IDXW-1:0]       rr_ptr;
  logic [IDXW-1:0]       win;
`endif

  always_comb begin
    req        = BusRd_out | BusRdX_out | BusUpgr_out;
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    for (int unsigned i = 0; i < NUM_CACHES; i++) begin
`ifdef MESI_BUS_FIXED_PRIO_EN
      scan = IDXW'(i);
`else
      scan = IDXW'((i + 32'(rr_ptr)) % NUM_CACHES);
`endif
      if (!pick_valid && req[scan]) begin
        pick_valid = 1'b1;
        pick_idx   = scan;
      end
    end
    pick_oh = '0;
    if (pick_valid) pick_oh[pick_idx] = 1'b1;
    // grant is the one-hot owner, so it doubles as the self-snoop mask
    snoop_shared = Shared & ~grant;
    snoop_flush  = Flush & ~grant;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state        <= S_IDLE;
      cmd          <= CMD_RD;
      mem_cnt      <= '0;
      BusRd_in     <= '0;
      BusRdX_in    <= '0;
      BusUpgr_in   <= '0;
      C_in         <= '0;
      grant        <= '0;
      xfer_done    <= '0;
      mem_rd       <= 1'b0;
      busy         <= 1'b0;
      protocol_err <= 1'b0;
`ifndef MESI_BUS_FIXED_PRIO_EN
      rr_ptr       <= '0;
      win          <= '0;
`endif
    end else begin
      xfer_done <= '0;
      unique case (state)
        S_IDLE: if (pick_valid) begin
          grant <= pick_oh;
          busy  <= 1'b1;
          state <= S_BCAST;
`ifndef MESI_BUS_FIXED_PRIO_EN
          win   <= pick_idx;
`endif
          if (BusRdX_out[pick_idx]) begin
            cmd       <= CMD_RDX;
            BusRdX_in <= ~pick_oh;
          end else if (BusUpgr_out[pick_idx]) begin
            cmd        <= CMD_UPGR;
            BusUpgr_in <= ~pick_oh;
          end else begin
            cmd      <= CMD_RD;
            BusRd_in <= ~pick_oh;
          end
        end
        S_BCAST: begin
          BusRd_in   <= '0;
          BusRdX_in  <= '0;
          BusUpgr_in <= '0;
          state      <= S_SNOOP;
        end
        S_SNOOP: begin
          C_in <= (snoop_shared != '0) ? grant : '0;
          if ((snoop_flush & (snoop_flush - 1'b1)) != '0) protocol_err <= 1'b1;
          // xfer_done is raised on entry so the pulse coincides with the DONE cycle
          if (snoop_flush != '0 || cmd == CMD_UPGR) begin
            xfer_done <= grant;
            state     <= S_DONE;
          end else begin
            mem_cnt <= 4'(MEM_LATENCY);
            mem_rd  <= 1'b1;
            state   <= S_MEM;
          end
        end
        S_MEM: begin
          if (mem_cnt == 4'd1) begin
            mem_cnt   <= '0;
            mem_rd    <= 1'b0;
            xfer_done <= grant;
            state     <= S_DONE;
          end else begin
            mem_cnt <= mem_cnt - 4'd1;
          end
        end
        S_DONE: begin
          grant <= '0;
          C_in  <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
`ifndef MESI_BUS_FIXED_PRIO_EN
          rr_ptr <= (32'(win) == NUM_CACHES - 1) ? '0 : win + IDXW'(1);
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mesi_snoop_bus_ctrl.sv
// Randomized self-checking bench for mesi_snoop_bus_ctrl against a transaction-level bus model.
module tb_mesi_snoop_bus_ctrl;
  localparam int N = 4;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rstb;
  logic [N-1:0] BusRd_out, BusRdX_out, BusUpgr_out, Flush, Shared;
  logic [N-1:0] BusRd_in, BusRdX_in, BusUpgr_in, C_in, grant, xfer_done;
  logic         mem_rd, busy, protocol_err;

  int           checks = 0;
  int           errors = 0;
  int           m_ptr  = 0;
  bit           m_perr = 1'b0;
  logic [N-1:0] last_grant;
  logic [N-1:0] exp_order [4];
  logic [N-1:0] fl, ex;
  logic [2:0]   v;
  int           w, r;

  mesi_snoop_bus_ctrl #(.NUM_CACHES(N), .MEM_LATENCY(L)) dut (
    .clk(clk), .rstb(rstb),
    .BusRd_out(BusRd_out), .BusRdX_out(BusRdX_out), .BusUpgr_out(BusUpgr_out),
    .Flush(Flush), .Shared(Shared),
    .BusRd_in(BusRd_in), .BusRdX_in(BusRdX_in), .BusUpgr_in(BusUpgr_in),
    .C_in(C_in), .grant(grant), .xfer_done(xfer_done),
    .mem_rd(mem_rd), .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] rq);
`ifdef MESI_BUS_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (rq[i]) return i;
`else
    for (int i = 0; i < N; i++) if (rq[(m_ptr + i) % N]) return (m_ptr + i) % N;
`endif
    return -1;
  endfunction

  // 0 = BusRd, 1 = BusRdX, 2 = BusUpgr
  function automatic int model_cmd(input int c);
    if (BusRdX_out[c]) return 1;
    if (BusUpgr_out[c]) return 2;
    return 0;
  endfunction

  // Entered at a negedge with the DUT idle and requests already driven; returns at the next idle negedge.
  task automatic run_txn(input logic [N-1:0] sh, input logic [N-1:0] flv, input bit withdraw, output int wi);
    logic [N-1:0] oh, others, ms, mf, exp_c, zero;
    int c, mem;
    zero = '0;
    wi = model_pick(BusRd_out | BusRdX_out | BusUpgr_out);
    if (wi < 0) return;
    oh = '0; oh[wi] = 1'b1;
    others = ~oh;
    c = model_cmd(wi);
    check("idle_grant", grant, 0);
    check("idle_busy", busy, 0);
    @(negedge clk);
    last_grant = grant;
    check("grant", grant, oh);
    check("busy", busy, 1);
    check("bcast_rd", BusRd_in, (c == 0) ? others : zero);
    check("bcast_rdx", BusRdX_in, (c == 1) ? others : zero);
    check("bcast_upgr", BusUpgr_in, (c == 2) ? others : zero);
    check("bcast_mem_rd", mem_rd, 0);
    if (withdraw) begin
      BusRd_out[wi] = 1'b0; BusRdX_out[wi] = 1'b0; BusUpgr_out[wi] = 1'b0;
    end
    @(negedge clk);
    check("bcast_clear", BusRd_in | BusRdX_in | BusUpgr_in, 0);
    check("snoop_grant", grant, oh);
    check("snoop_xfer", xfer_done, 0);
    Shared = sh;
    Flush  = flv;
    ms = sh & others;
    mf = flv & others;
    exp_c = (ms != '0) ? oh : zero;
    if ($countones(mf) > 1) m_perr = 1'b1;
    mem = (mf != '0 || c == 2) ? 0 : L;
    for (int k = 0; k <= mem; k++) begin
      @(negedge clk);
      Shared = '0;
      Flush  = '0;
      check("mem_rd", mem_rd, k < mem);
      check("xfer_done", xfer_done, (k == mem) ? oh : zero);
      check("c_in", C_in, exp_c);
      check("hold_grant", grant, oh);
      check("busy_hold", busy, 1);
      check("perr", protocol_err, m_perr);
    end
    BusRd_out[wi] = 1'b0; BusRdX_out[wi] = 1'b0; BusUpgr_out[wi] = 1'b0;
    m_ptr = (wi + 1) % N;
    @(negedge clk);
    check("idle_after", {grant, C_in, xfer_done, mem_rd, busy}, 0);
    check("perr_idle", protocol_err, m_perr);
  endtask

  task automatic do_reset;
    @(negedge clk);
    #2 rstb = 1'b0;
    #1 check("rst_outs", {BusRd_in, BusRdX_in, BusUpgr_in, C_in, grant, xfer_done, mem_rd, busy, protocol_err}, 0);
    @(negedge clk);
    rstb   = 1'b1;
    m_ptr  = 0;
    m_perr = 1'b0;
  endtask

  initial begin
`ifdef MESI_BUS_FIXED_PRIO_EN
    exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
`endif
    BusRd_out = '0; BusRdX_out = '0; BusUpgr_out = '0; Flush = '0; Shared = '0;
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_init", {BusRd_in, BusRdX_in, BusUpgr_in, C_in, grant, xfer_done, mem_rd, busy, protocol_err}, 0);
    rstb = 1'b1;
    repeat (2) @(negedge clk);
    check("no_req_idle", {busy, grant}, 0);

    BusRd_out[0] = 1'b1;
    run_txn('0, '0, 1'b0, w);
    BusRd_out[2] = 1'b1;
    run_txn(4'b0010, '0, 1'b0, w);
    BusRdX_out[3] = 1'b1;
    run_txn('0, 4'b0001, 1'b0, w);

    do_reset();
    BusRd_out = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      BusRd_out[0] = 1'b1;
      run_txn('0, '0, 1'b0, w);
      check("order", last_grant, exp_order[i]);
    end
    BusRd_out = '0;

    BusUpgr_out[1] = 1'b1;
    run_txn('0, 4'b0101, 1'b0, w);
    BusRd_out[2] = 1'b1;
    run_txn(4'b0001, '0, 1'b0, w);

    do_reset();
    BusRd_out[1] = 1'b1;
    run_txn('0, '0, 1'b0, w);
    BusRd_out[3] = 1'b1;
    BusRd_out[0] = 1'b1;
    ex = '0;
    ex[model_pick(BusRd_out)] = 1'b1;
    @(negedge clk);
    check("pre_rst_grant", grant, ex);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_mem", mem_rd, 1);
    do_reset();
    run_txn('0, '0, 1'b0, w);
    check("rst_fresh_grant", last_grant, 4'b0001);

    for (int t = 0; t < 150; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!(BusRd_out[i] | BusRdX_out[i] | BusUpgr_out[i]) && $urandom_range(0, 2) != 0) begin
          v = 3'($urandom_range(1, 7));
          BusRd_out[i] = v[0]; BusRdX_out[i] = v[1]; BusUpgr_out[i] = v[2];
        end
      end
      if ((BusRd_out | BusRdX_out | BusUpgr_out) == '0) BusRd_out[$urandom_range(0, N - 1)] = 1'b1;
      r = int'($urandom_range(0, 9));
      fl = '0;
      if (r >= 9) fl = N'($urandom);
      else if (r >= 6) fl[$urandom_range(0, N - 1)] = 1'b1;
      run_txn(N'($urandom), fl, $urandom_range(0, 7) == 0, w);
      if (t == 75) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
